alu_responder: RTL
==================

# alu_responder

Request/response front-end for the ALU datapath: accepts one operation (two operands plus a 3-bit command) over a valid/ready request channel, computes it, and returns the result over a valid/ready response channel. This is the serving end for controller blocks that issue ALU commands, such as the button-driven board controllers. Single-cycle operations complete in one cycle. Multiplication runs as a multi-cycle shift-add sequence. Only one operation is in flight at a time.

## Interface
- `WIDTH`, default 3: operand and result width in bits; legal range 2..16.
- `clk` in 1: single clock, all state updates on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1: a request is presented.
- `req_ready` out 1: the block can accept a request.
- `req_a` in WIDTH: operand A.
- `req_b` in WIDTH: operand B.
- `req_cmd` in 3: operation code.
- `rsp_valid` out 1: response is valid.
- `rsp_ready` in 1: the consumer accepts the response.
- `rsp_result` out WIDTH: result.
- `rsp_carry` out 1: carry, borrow or overflow flag.
- `rsp_zero` out 1: `rsp_result` equals 0.

## Operation
- **FSM states**
  - IDLE: `req_ready`=1 (forced to 0 while `rst` is high).
  - CALC: multiplication in progress.
  - DONE: response held.
- **Accept:** `req_valid && req_ready` at a rising edge. `req_a`, `req_b` and `req_cmd` are captured into internal registers. Later input changes are ignored.
- **Transitions**
  - IDLE→DONE on accept when `cmd`≠111.
  - IDLE→CALC on accept when `cmd`=111.
  - CALC→DONE after exactly WIDTH cycles in CALC.
  - DONE→IDLE on `rsp_valid && rsp_ready`.
- **Commands** (all arithmetic is modulo 2^WIDTH):
  - 000 ADD: result = a+b; carry = carry-out of bit WIDTH-1.
  - 001 SUB: result = a−b; carry = 1 iff a<b (unsigned borrow).
  - 010 AND, 011 OR, 100 XOR: bitwise; carry=0.
  - 101 SHL: result = a<<b, zero fill. If b≥WIDTH, result=0. carry=0.
  - 110 SHR: logical right shift, same rules as SHL.
  - 111 MUL: unsigned shift-add. A 2·WIDTH-bit accumulator processes one multiplier bit per CALC cycle, LSB first. result = low WIDTH bits of the product; carry = 1 iff the high WIDTH bits are nonzero.
- **Response:** `rsp_zero` = (`rsp_result`==0), registered together with the result.
- **Flow control:** no request overlap. `req_ready`=0 in CALC and DONE, including the cycle in which the response handshake completes. A new request is accepted no earlier than the cycle after the response handshake.
- **Reset:** asserting `rst` at any time, including mid-CALC or in DONE, immediately returns the block to IDLE and clears all registers. Any in-flight operation is discarded and no response is produced.
- **Reset values:** `rsp_valid`=0, `rsp_result`=0, `rsp_carry`=0, `rsp_zero`=0, `req_ready`=0 while `rst` is high and 1 from the first cycle after release.

## Timing
- **Single-cycle ops:** accept at edge N → `rsp_valid`=1 after edge N+1 (latency 1).
- **MUL:** accept at edge N → `rsp_valid`=1 after edge N+WIDTH+1 (WIDTH=3 gives latency 4).
- **Registered outputs:** `rsp_valid`, `rsp_result`, `rsp_carry` and `rsp_zero` come straight from registers with no combinational path from inputs. `req_ready` is decoded from state only, gated by `rst`.
- **Back-pressure:** while `rsp_valid`=1 and `rsp_ready`=0, all `rsp_*` outputs hold stable for any number of cycles.
- **`rsp_ready` high early:** a high `rsp_ready` before `rsp_valid` has no effect. The handshake completes on the first edge with both high.
- **Ignored requests:** `req_valid` asserted while `req_ready`=0 is ignored and captures nothing. The requester must keep the request asserted.

## Test plan
- **ADD, no back-pressure:** WIDTH=3, ADD a=4 b=5, `rsp_ready`=1 → one cycle after accept: `rsp_valid`=1, result=1, carry=1, zero=0. `req_ready` returns the cycle after the handshake.
- **SUB borrow and zero flag:**
  - SUB a=2 b=5 → result=5, carry=1.
  - SUB a=3 b=3 → result=0, carry=0, zero=1.
- **MUL overflow and latency:** MUL a=3 b=3 → `rsp_valid` asserted exactly 4 cycles after accept, result=1, carry=1.
  - MUL a=2 b=3 → result=6, carry=0.
  - `req_ready`=0 throughout CALC. A second `req_valid` pulse during CALC is ignored.
- **Shifts:**
  - SHL a=3 b=4 → result=0, zero=1.
  - SHR a=6 b=1 → result=3.
  - XOR a=5 b=3 → result=6, carry=0.
- **Back-pressure:** AND a=7 b=5 with `rsp_ready`=0 for 5 cycles → result=5 held stable with `rsp_valid`=1 and `req_ready`=0 throughout. Raising `rsp_ready` completes the handshake on the next edge.
- **Reset mid-MUL:** assert `rst` asynchronously in the 2nd CALC cycle → outputs clear immediately. After release: `req_ready`=1, `rsp_valid` stays 0, and a following ADD 1+1 returns 2.

Source files
------------

// File: rtl/alu_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_if
// Purpose  : Request/response bundle between an ALU command issuer and the
//            alu_responder. One request (two operands plus a 3-bit command)
//            travels over a valid/ready channel; the result comes back over a
//            second valid/ready channel.
// Signals  : req_valid/req_ready      request handshake
//            req_a, req_b, req_cmd    operands and operation code
//            rsp_valid/rsp_ready      response handshake
//            rsp_result, rsp_carry,   result, carry/borrow/overflow flag,
//            rsp_zero                 result-is-zero flag
// Modports : master - command issuer, slave - alu_responder
// Revision : 1.0 - initial release
// ============================================================================
interface alu_if #(
  parameter int WIDTH = 3
);
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic [2:0]       req_cmd;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_carry;
  logic             rsp_zero;

  modport master (
    output req_valid, req_a, req_b, req_cmd, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_carry, rsp_zero
  );

  modport slave (
    input  req_valid, req_a, req_b, req_cmd, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_carry, rsp_zero
  );
endinterface
`default_nettype wire

// File: rtl/alu_responder.sv
`default_nettype none
// ============================================================================
// Module   : alu_responder
// Purpose  : Serves one ALU operation at a time. Single-cycle commands
//            (ADD, SUB, AND, OR, XOR, SHL, SHR) are computed on accept and
//            the response is presented on the next cycle. MUL runs as an
//            LSB-first shift-add sequence over WIDTH cycles.
// Ports    : clk  - clock, rising edge
//            rst  - asynchronous active-high reset
//            bus  - alu_if slave modport (request and response channels)
// Params   : WIDTH - operand/result width, 2..16
// Revision : 1.0 - initial release
// ============================================================================
module alu_responder #(
  parameter int WIDTH = 3
) (
  input  wire  clk,
  input  wire  rst,
  alu_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);
  // Shift amounts at or beyond this value shift everything out.
  localparam logic [WIDTH-1:0] SHIFT_LIM = WIDTH'(WIDTH);

  localparam logic [2:0] CMD_ADD = 3'b000;
  localparam logic [2:0] CMD_SUB = 3'b001;
  localparam logic [2:0] CMD_AND = 3'b010;
  localparam logic [2:0] CMD_OR  = 3'b011;
  localparam logic [2:0] CMD_XOR = 3'b100;
  localparam logic [2:0] CMD_SHL = 3'b101;
  localparam logic [2:0] CMD_SHR = 3'b110;
  localparam logic [2:0] CMD_MUL = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;           // multiplicand
  logic [2*WIDTH-1:0] acc_q, acc_d;       // {partial product, remaining multiplier}
  logic [CNT_W-1:0]   cnt_q, cnt_d;       // completed multiply steps
  logic               rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0]   rsp_result_q, rsp_result_d;
  logic               rsp_carry_q, rsp_carry_d;
  logic               rsp_zero_q, rsp_zero_d;

  // --------------------------------------------------------------------------
  // Single-cycle ALU, evaluated directly on the request operands so the
  // response can be registered on the accept edge.
  // --------------------------------------------------------------------------
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   diff_ext;
  logic [WIDTH-1:0] alu_result;
  logic             alu_carry;

  always_comb begin
    sum_ext    = {1'b0, bus.req_a} + {1'b0, bus.req_b};
    // The extra top bit of the difference is set exactly when a < b.
    diff_ext   = {1'b0, bus.req_a} - {1'b0, bus.req_b};
    alu_result = '0;
    alu_carry  = 1'b0;
    case (bus.req_cmd)
      CMD_ADD: {alu_carry, alu_result} = sum_ext;
      CMD_SUB: {alu_carry, alu_result} = diff_ext;
      CMD_AND: alu_result = bus.req_a & bus.req_b;
      CMD_OR:  alu_result = bus.req_a | bus.req_b;
      CMD_XOR: alu_result = bus.req_a ^ bus.req_b;
      CMD_SHL: alu_result = (bus.req_b >= SHIFT_LIM) ? '0 : (bus.req_a << bus.req_b);
      CMD_SHR: alu_result = (bus.req_b >= SHIFT_LIM) ? '0 : (bus.req_a >> bus.req_b);
      default: begin
        alu_result = '0;
        alu_carry  = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // One shift-add multiply step. The low half of the accumulator holds the
  // not-yet-consumed multiplier bits; its LSB decides whether the multiplicand
  // is added into the high half. The add is one bit wider than the high half
  // and that carry shifts back in, so after WIDTH steps the accumulator holds
  // the full 2*WIDTH-bit product.
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0]   mul_addend;
  logic [WIDTH:0]     mul_hi_sum;
  logic [2*WIDTH-1:0] acc_step;
  logic [WIDTH-1:0]   mul_result;
  logic               mul_carry;

  always_comb begin
    mul_addend = acc_q[0] ? a_q : '0;
    mul_hi_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mul_addend};
    acc_step   = {mul_hi_sum, acc_q[WIDTH-1:1]};
    mul_result = acc_step[WIDTH-1:0];
    mul_carry  = |acc_step[2*WIDTH-1:WIDTH];
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_carry_d  = rsp_carry_q;
    rsp_zero_d   = rsp_zero_q;

    case (state_q)
      S_IDLE: begin
        // req_ready is high throughout IDLE outside reset, so req_valid
        // alone marks the accept edge here.
        if (bus.req_valid) begin
          a_d = bus.req_a;
          if (bus.req_cmd == CMD_MUL) begin
            acc_d   = {{WIDTH{1'b0}}, bus.req_b};
            cnt_d   = '0;
            state_d = S_CALC;
          end else begin
            rsp_result_d = alu_result;
            rsp_carry_d  = alu_carry;
            rsp_zero_d   = (alu_result == '0);
            rsp_valid_d  = 1'b1;
            state_d      = S_DONE;
          end
        end
      end

      S_CALC: begin
        acc_d = acc_step;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_STEP) begin
          rsp_result_d = mul_result;
          rsp_carry_d  = mul_carry;
          rsp_zero_d   = (mul_result == '0);
          rsp_valid_d  = 1'b1;
          state_d      = S_DONE;
        end
      end

      S_DONE: begin
        // Response fields stay as they are after the handshake; only
        // rsp_valid drops.
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end

      default: begin
        state_d     = S_IDLE;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      a_q          <= '0;
      acc_q        <= '0;
      cnt_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_carry_q  <= 1'b0;
      rsp_zero_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_carry_q  <= rsp_carry_d;
      rsp_zero_q   <= rsp_zero_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  // Gating with rst keeps req_ready low for the whole reset pulse even though
  // the state register already reads IDLE.
  assign bus.req_ready  = (state_q == S_IDLE) && !rst;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_carry  = rsp_carry_q;
  assign bus.rsp_zero   = rsp_zero_q;

endmodule
`default_nettype wire
